// File: rtl/apb_uart16550_host.sv
// rtl/apb_uart16550_host.sv - APB4 requester issuing single register transfers to a UART16550 slave.
// Optional ACCESS-phase timeout abort is enabled by defining APB_HOST_TIMEOUT_EN.
module apb_uart16550_host #(
  parameter int              ADDR_WIDTH = 3,
  parameter logic [2:0]      PPROT_VAL  = 3'b000,
  parameter int              TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [7:0]            rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [7:0]            PWDATA,
  output logic                  PSTRB,
  output logic [2:0]            PPROT,
  input  logic [7:0]            PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

`ifdef APB_HOST_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);
  // Abort fires in the cycle whose stall would bring the count up to TIMEOUT.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;
`endif

  assign cmd_ready_o = (state == IDLE) && !rst_i;
  assign busy_o      = (state != IDLE);
  assign PPROT       = PPROT_VAL;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= 8'h00;
      PSTRB       <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 8'h00;
      rsp_err_o   <= 1'b0;
`ifdef APB_HOST_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            PADDR  <= cmd_addr_i;
            PWRITE <= cmd_write_i;
            PWDATA <= cmd_wdata_i;
            PSTRB  <= cmd_write_i;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
`ifdef APB_HOST_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= PWRITE ? 8'h00 : PRDATA;
            rsp_err_o   <= PSLVERR;
            state       <= RESP;
          end
`ifdef APB_HOST_TIMEOUT_EN
          else if (wait_cnt == LIMIT) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= 8'h00;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
